// File: rtl/pwm_phase_controller.sv
// Complementary switching-clock sequencer: period counter, phase-shifted Fsw_bar,
// double-buffered validated config, start/stop-at-boundary and fault shutdown.
module pwm_phase_controller #(
  parameter int CNT_W      = 8,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_ON     = 2,
  parameter int DEF_PHASE  = 5,
  parameter int DEF_DEAD   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fault,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_on,
  input  logic [CNT_W-1:0] cfg_phase,
  input  logic [CNT_W-1:0] cfg_dead,
  input  logic             cfg_load,
  output logic             cfg_busy,
  output logic             cfg_err,
  output logic             Fsw,
  output logic             Fsw_bar,
  output logic             running,
  output logic             fault_latched
);

  localparam int W1 = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP, S_FAULT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d, on_q, on_d, ph_q, ph_d, dead_q, dead_d;
  logic [CNT_W-1:0] pper_q, pper_d, pon_q, pon_d, pph_q, pph_d, pdead_q, pdead_d;
  logic             busy_q, busy_d, err_q, err_d;
  logic             fsw_q, fsw_d, fswb_q, fswb_d;
  logic [CNT_W-1:0] gap_q, gap_d;

  logic             drive, boundary, switching, apply;
  logic             cfg_ok;
  logic [W1-1:0]    v_per, v_on, v_ph, v_dead, v_need, v_room;
  logic [W1-1:0]    ph_pos;
  logic             fsw_raw, fswb_raw, gap_ok;

  // Validation is done in CNT_W+1 bits so on+dead cannot wrap.
  always_comb begin
    v_per  = {1'b0, cfg_period};
    v_on   = {1'b0, cfg_on};
    v_ph   = {1'b0, cfg_phase};
    v_dead = {1'b0, cfg_dead};
    v_need = v_on + v_dead;
    v_room = v_per - v_ph;
    cfg_ok = (v_per >= W1'(2)) && (v_on >= W1'(1)) && (v_on < v_per) &&
             (v_ph < v_per) && (v_ph >= v_need) && (v_room >= v_need);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    on_d    = on_q;
    ph_d    = ph_q;
    dead_d  = dead_q;
    pper_d  = pper_q;
    pon_d   = pon_q;
    pph_d   = pph_q;
    pdead_d = pdead_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    drive   = 1'b0;

    boundary  = (cnt_q == per_q - 1'b1);
    switching = (state_q == S_RUN) || (state_q == S_STOP);
    apply     = busy_q && (!switching || boundary);

    if (apply) begin
      per_d  = pper_q;
      on_d   = pon_q;
      ph_d   = pph_q;
      dead_d = pdead_q;
      busy_d = 1'b0;
    end

    // A load seen while busy_q is set (including on the apply edge) is dropped.
    if (cfg_load && !busy_q) begin
      if (cfg_ok) begin
        pper_d  = cfg_period;
        pon_d   = cfg_on;
        pph_d   = cfg_phase;
        pdead_d = cfg_dead;
        busy_d  = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (fault) begin
      state_d = S_FAULT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_d = S_RUN;
            cnt_d   = '0;
            drive   = 1'b1;
          end
        end
        S_RUN: begin
          cnt_d = boundary ? '0 : cnt_q + 1'b1;
          drive = 1'b1;
          if (!enable) state_d = S_STOP;
        end
        S_STOP: begin
          cnt_d = boundary ? '0 : cnt_q + 1'b1;
          drive = 1'b1;
          if (enable) begin
            state_d = S_RUN;
          end else if (boundary) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            drive   = 1'b0;
          end
        end
        S_FAULT: begin
          if (!enable) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are computed from next-cnt and next-active config so they line up with cnt_q.
  // A rising edge is held off until the both-low gap reaches the active dead-time; valid
  // configs always satisfy this, so it only bites when a larger dead-time is applied.
  always_comb begin
    fsw_raw = (cnt_d < on_d);
    ph_pos  = {1'b0, cnt_d} + {1'b0, per_d} - {1'b0, ph_d};
    if (ph_pos >= {1'b0, per_d}) ph_pos = ph_pos - {1'b0, per_d};
    fswb_raw = (ph_pos < {1'b0, on_d});
    gap_ok   = (gap_q >= dead_d);
    fsw_d    = drive && fsw_raw  && (fsw_q  || gap_ok);
    fswb_d   = drive && fswb_raw && (fswb_q || gap_ok);
    if (fsw_d || fswb_d)          gap_d = '0;
    else if (gap_q == '1)         gap_d = gap_q;
    else                          gap_d = gap_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      per_q   <= CNT_W'(DEF_PERIOD);
      on_q    <= CNT_W'(DEF_ON);
      ph_q    <= CNT_W'(DEF_PHASE);
      dead_q  <= CNT_W'(DEF_DEAD);
      pper_q  <= '0;
      pon_q   <= '0;
      pph_q   <= '0;
      pdead_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      fsw_q   <= 1'b0;
      fswb_q  <= 1'b0;
      gap_q   <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      on_q    <= on_d;
      ph_q    <= ph_d;
      dead_q  <= dead_d;
      pper_q  <= pper_d;
      pon_q   <= pon_d;
      pph_q   <= pph_d;
      pdead_q <= pdead_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      fsw_q   <= fsw_d;
      fswb_q  <= fswb_d;
      gap_q   <= gap_d;
    end
  end

  assign cfg_busy      = busy_q;
  assign cfg_err       = err_q;
  assign Fsw           = fsw_q;
  assign Fsw_bar       = fswb_q;
  assign running       = (state_q == S_RUN) || (state_q == S_STOP);
  assign fault_latched = (state_q == S_FAULT);

endmodule

// File: tb/tb_pwm_phase_controller.sv
// Directed bench for pwm_phase_controller: waveform masks are hand-derived per config.
module tb_pwm_phase_controller;

  logic       clk = 1'b0;
  logic       reset, enable, fault, cfg_load;
  logic [7:0] cfg_period, cfg_on, cfg_phase, cfg_dead;
  logic       cfg_busy, cfg_err, Fsw, Fsw_bar, running, fault_latched;

  int n_chk = 0;
  int n_err = 0;

  // Expected model: Fsw / Fsw_bar high where the mask bit at the current count is set.
  int          m_per;
  int          m_cnt;
  logic [31:0] m_fsw, m_fswb;

  pwm_phase_controller dut (
    .clk(clk), .reset(reset), .enable(enable), .fault(fault),
    .cfg_period(cfg_period), .cfg_on(cfg_on), .cfg_phase(cfg_phase), .cfg_dead(cfg_dead),
    .cfg_load(cfg_load), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .Fsw(Fsw), .Fsw_bar(Fsw_bar), .running(running), .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_chk(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check({tag, "_fsw"},  Fsw,     m_fsw[m_cnt]);
      check({tag, "_fswb"}, Fsw_bar, m_fswb[m_cnt]);
      check({tag, "_ovl"},  Fsw & Fsw_bar, 1'b0);
      tick();
      m_cnt = (m_cnt == m_per - 1) ? 0 : m_cnt + 1;
    end
  endtask

  task automatic set_default_model();
    m_per  = 10;
    m_fsw  = 32'h0000_0003;   // cnt 0-1
    m_fswb = 32'h0000_0060;   // cnt 5-6
  endtask

  task automatic set_cfg(input int p, input int o, input int ph, input int d);
    cfg_period = 8'(p);
    cfg_on     = 8'(o);
    cfg_phase  = 8'(ph);
    cfg_dead   = 8'(d);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; fault = 1'b0; cfg_load = 1'b0;
    set_cfg(0, 0, 0, 0);
    set_default_model();
    m_cnt = 0;

    @(negedge clk);
    check("rst_fsw",   Fsw, 1'b0);
    check("rst_fswb",  Fsw_bar, 1'b0);
    check("rst_run",   running, 1'b0);
    check("rst_fault", fault_latched, 1'b0);
    check("rst_busy",  cfg_busy, 1'b0);
    check("rst_err",   cfg_err, 1'b0);

    // Default run
    reset = 1'b1; enable = 1'b1;
    tick();
    m_cnt = 0;
    check("start_run", running, 1'b1);
    run_chk(20, "def");

    // Live reconfig to period 20 / on 4 / phase 10 / dead 2, loaded at cnt 3
    run_chk(3, "pre");
    set_cfg(20, 4, 10, 2); cfg_load = 1'b1;
    run_chk(1, "ld");
    cfg_load = 1'b0;
    check("rc_busy1", cfg_busy, 1'b1);
    set_cfg(0, 0, 0, 0); cfg_load = 1'b1;     // invalid but busy: must be ignored
    run_chk(1, "ldbusy");
    cfg_load = 1'b0;
    check("busy_noerr", cfg_err, 1'b0);
    run_chk(4, "old");
    check("rc_busy9", cfg_busy, 1'b1);
    run_chk(1, "old9");
    m_per = 20; m_fsw = 32'h0000_000F; m_fswb = 32'h0000_3C00;
    check("rc_busy_clr", cfg_busy, 1'b0);
    run_chk(40, "p20");

    // Invalid load: phase 5 < on 4 + dead 2
    set_cfg(10, 4, 5, 2); cfg_load = 1'b1;
    run_chk(1, "inv");
    cfg_load = 1'b0;
    check("inv_err", cfg_err, 1'b1);
    check("inv_busy", cfg_busy, 1'b0);
    run_chk(1, "inv2");
    check("inv_err_clr", cfg_err, 1'b0);
    run_chk(18, "inv_wave");

    // Restore defaults through a load at cnt 0 of the 20-period
    set_cfg(10, 2, 5, 1); cfg_load = 1'b1;
    run_chk(1, "rest");
    cfg_load = 1'b0;
    check("rest_busy", cfg_busy, 1'b1);
    run_chk(19, "rest_old");
    set_default_model();
    check("rest_busy_clr", cfg_busy, 1'b0);
    run_chk(10, "rest_new");

    // Graceful stop: enable drops at cnt 3, drain to the wrap
    run_chk(3, "stp_a");
    enable = 1'b0;
    run_chk(1, "stp_b");
    check("stop_running", running, 1'b1);
    run_chk(6, "drain");
    check("idle_fsw",  Fsw, 1'b0);
    check("idle_fswb", Fsw_bar, 1'b0);
    check("idle_run",  running, 1'b0);
    tick();
    check("idle_hold", Fsw | Fsw_bar, 1'b0);

    // Re-raise enable at cnt 7 while stopping: uninterrupted
    enable = 1'b1;
    tick();
    m_cnt = 0;
    run_chk(3, "rr_a");
    enable = 1'b0;
    run_chk(4, "rr_b");
    check("rr_run7", running, 1'b1);
    enable = 1'b1;
    run_chk(13, "rr_c");
    check("rr_run", running, 1'b1);

    // Fault while Fsw is high
    check("pre_fault_fsw", Fsw, 1'b1);
    fault = 1'b1;
    tick();
    check("flt_fsw",  Fsw, 1'b0);
    check("flt_fswb", Fsw_bar, 1'b0);
    check("flt_lat",  fault_latched, 1'b1);
    check("flt_run",  running, 1'b0);
    fault = 1'b0;
    tick(); tick();
    check("flt_hold", fault_latched, 1'b1);
    enable = 1'b0;
    tick();
    check("flt_exit", fault_latched, 1'b0);
    check("flt_idle", running, 1'b0);

    // Async reset mid-period with a pending config
    enable = 1'b1;
    tick();
    m_cnt = 0;
    set_cfg(20, 4, 10, 2); cfg_load = 1'b1;
    run_chk(1, "ar_ld");
    cfg_load = 1'b0;
    check("ar_busy", cfg_busy, 1'b1);
    run_chk(4, "ar_run");
    check("ar_fswb_hi", Fsw_bar, 1'b1);
    reset = 1'b0;
    #1;
    check("ar_fswb", Fsw_bar, 1'b0);
    check("ar_fsw",  Fsw, 1'b0);
    check("ar_busy0", cfg_busy, 1'b0);
    check("ar_run0", running, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    set_default_model();
    m_cnt = 0;
    run_chk(20, "ar_def");
    check("ar_busy_after", cfg_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
